// File: rtl/fb_alpha_blend.sv
// Three-stage alpha blend: Q4.12 source over promoted destination, saturated and packed to RGB565.
// Defining FB_ALPHA_BLEND_DITHER_EN adds 4x4 ordered dither ahead of the RGB565 truncation.
module fb_alpha_blend #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [15:0]       in_src_r,
  input  logic [15:0]       in_src_g,
  input  logic [15:0]       in_src_b,
  input  logic [15:0]       in_src_a,
  input  logic [15:0]       in_dst_r,
  input  logic [15:0]       in_dst_g,
  input  logic [15:0]       in_dst_b,
  input  logic [1:0]        in_x2,
  input  logic [1:0]        in_y2,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_rgb565,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [1:0] MODE_DIS = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_SUB = 2'd2;

  // Handshake: a transfer happens on any clk edge where valid && ready; the whole
  // pipe moves only when the output register is empty or being drained (no skid buffer).
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic [15:0] mul_q12(input logic [15:0] c, input logic [12:0] k);
    logic signed [31:0] cs, ks, p;
    cs = {{16{c[15]}}, c};
    ks = {19'd0, k};
    p  = cs * ks;
    return 16'(p >>> 12);
  endfunction

  function automatic logic [12:0] combine(input logic [1:0] mode, input logic [15:0] src,
                                          input logic [15:0] dst, input logic [15:0] ps,
                                          input logic [15:0] pd);
    logic signed [17:0] s, d, p, q, sum;
    s = {{2{src[15]}}, src};
    d = {{2{dst[15]}}, dst};
    p = {{2{ps[15]}}, ps};
    q = {{2{pd[15]}}, pd};
    case (mode)
      MODE_DIS: sum = s;
      MODE_ADD: sum = p + d;
      MODE_SUB: sum = p - d;
      default:  sum = p + q;
    endcase
    if (sum < 18'sd0)         return 13'd0;
    else if (sum > 18'sd4096) return 13'h1000;
    else                      return sum[12:0];
  endfunction

  function automatic logic [4:0] pack5(input logic [12:0] v, input logic [6:0] bias);
    logic [13:0] vd;
    vd = {1'b0, v} + {7'd0, bias};
    if (vd >= 14'h1000) return 5'h1f;
    return vd[11:7];
  endfunction

  function automatic logic [5:0] pack6(input logic [12:0] v, input logic [6:0] bias);
    logic [13:0] vd;
    vd = {1'b0, v} + {7'd0, bias};
    if (vd >= 14'h1000) return 6'h3f;
    return vd[11:6];
  endfunction

  // S1: clamp alpha, form source and destination weighted products
  logic [2:0][15:0] src_c, dst_c, ps_c, pd_c;
  logic [12:0]      a_cl, a_inv;

  assign src_c = {in_src_b, in_src_g, in_src_r};
  assign dst_c = {in_dst_b, in_dst_g, in_dst_r};

  always_comb begin
    if (in_src_a[15])              a_cl = 13'd0;
    else if (in_src_a > 16'h1000)  a_cl = 13'h1000;
    else                           a_cl = in_src_a[12:0];
    a_inv = 13'h1000 - a_cl;
    for (int i = 0; i < 3; i++) begin
      ps_c[i] = mul_q12(src_c[i], a_cl);
      pd_c[i] = mul_q12(dst_c[i], a_inv);
    end
  end

  logic              s1_valid;
  logic [1:0]        s1_mode, s1_x2, s1_y2;
  logic [ADDR_W-1:0] s1_addr;
  logic [2:0][15:0]  s1_src, s1_dst, s1_ps, s1_pd;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_x2    <= '0;
      s1_y2    <= '0;
      s1_addr  <= '0;
      s1_src   <= '0;
      s1_dst   <= '0;
      s1_ps    <= '0;
      s1_pd    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_x2    <= in_x2;
      s1_y2    <= in_y2;
      s1_addr  <= in_addr;
      s1_src   <= src_c;
      s1_dst   <= dst_c;
      s1_ps    <= ps_c;
      s1_pd    <= pd_c;
    end
  end

  // S2: mode-selected combine, clamped to [0, 1.0]
  logic [2:0][12:0] v_c;
  always_comb begin
    for (int i = 0; i < 3; i++)
      v_c[i] = combine(s1_mode, s1_src[i], s1_dst[i], s1_ps[i], s1_pd[i]);
  end

  logic              s2_valid;
  logic [1:0]        s2_x2, s2_y2;
  logic [ADDR_W-1:0] s2_addr;
  logic [2:0][12:0]  s2_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_x2    <= '0;
      s2_y2    <= '0;
      s2_addr  <= '0;
      s2_v     <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_x2    <= s1_x2;
      s2_y2    <= s1_y2;
      s2_addr  <= s1_addr;
      s2_v     <= v_c;
    end
  end

  // S3: optional ordered-dither bias, then saturate and truncate to 5/6/5
  logic [3:0] t;
`ifdef FB_ALPHA_BLEND_DITHER_EN
  always_comb begin
    case ({s2_y2, s2_x2})
      4'd0:  t = 4'd0;   4'd1:  t = 4'd8;   4'd2:  t = 4'd2;   4'd3:  t = 4'd10;
      4'd4:  t = 4'd12;  4'd5:  t = 4'd4;   4'd6:  t = 4'd14;  4'd7:  t = 4'd6;
      4'd8:  t = 4'd3;   4'd9:  t = 4'd11;  4'd10: t = 4'd1;   4'd11: t = 4'd9;
      4'd12: t = 4'd15;  4'd13: t = 4'd7;   4'd14: t = 4'd13;  default: t = 4'd5;
    endcase
  end
`else
  logic unused_dither;
  assign unused_dither = ^{s2_y2, s2_x2};
  assign t = 4'd0;
`endif

  logic [4:0] r5, b5;
  logic [5:0] g6;
  assign r5 = pack5(s2_v[0], {t, 3'b000});
  assign g6 = pack6(s2_v[1], {1'b0, t, 2'b00});
  assign b5 = pack5(s2_v[2], {t, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_rgb565 <= '0;
      out_addr   <= '0;
    end else if (adv) begin
      out_valid  <= s2_valid;
      out_rgb565 <= {r5, g6, b5};
      out_addr   <= s2_addr;
    end
  end

endmodule

// File: tb/tb_fb_alpha_blend.sv
// Bench for fb_alpha_blend: directed blend cases, backpressure, mid-stream reset and random traffic
// scored against an integer-arithmetic model of the blend rules.
module tb_fb_alpha_blend;
  localparam int ADDR_W = 24;

  typedef struct packed {
    logic [1:0]        mode;
    logic [2:0][15:0]  src;
    logic [15:0]       a;
    logic [2:0][15:0]  dst;
    logic [1:0]        x2;
    logic [1:0]        y2;
    logic [ADDR_W-1:0] addr;
  } frag_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] in_mode, in_x2, in_y2;
  logic [15:0] in_src_r, in_src_g, in_src_b, in_src_a, in_dst_r, in_dst_g, in_dst_b;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [15:0] out_rgb565;

  fb_alpha_blend #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_src_r(in_src_r), .in_src_g(in_src_g), .in_src_b(in_src_b), .in_src_a(in_src_a),
    .in_dst_r(in_dst_r), .in_dst_g(in_dst_g), .in_dst_b(in_dst_b),
    .in_x2(in_x2), .in_y2(in_y2), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb565(out_rgb565), .out_addr(out_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int last_lat = 0;
  logic [15:0] last_rgb;
  logic [ADDR_W+15:0] exp_q[$];
  int acc_q[$];
  frag_t cur;
  logic chk_stall = 1'b0;
  logic [15:0] held_rgb;
  logic [ADDR_W-1:0] held_addr;

`ifdef FB_ALPHA_BLEND_DITHER_EN
  int bayer[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: blend rules in plain integer arithmetic
  function automatic logic [15:0] ref_pixel(input frag_t f);
    int a, s, d, ps, pd, v, t, vv, limit, scale;
    int ch[3];
    a = $signed(f.a);
    if (a < 0) a = 0;
    if (a > 4096) a = 4096;
    t = 0;
`ifdef FB_ALPHA_BLEND_DITHER_EN
    t = bayer[int'(f.y2) * 4 + int'(f.x2)];
`endif
    for (int c = 0; c < 3; c++) begin
      s  = $signed(f.src[c]);
      d  = $signed(f.dst[c]);
      ps = (s * a) >>> 12;
      pd = (d * (4096 - a)) >>> 12;
      case (f.mode)
        2'd0:    v = s;
        2'd1:    v = ps + d;
        2'd2:    v = ps - d;
        default: v = ps + pd;
      endcase
      if (v < 0) v = 0;
      if (v > 4096) v = 4096;
      limit = (c == 1) ? 64 : 32;
      scale = 4096 / limit;
      vv = v + t * (scale / 16);
      ch[c] = (vv >= 4096) ? limit - 1 : vv / scale;
    end
    return 16'(ch[0] * 2048 + ch[1] * 32 + ch[2]);
  endfunction

  function automatic logic [15:0] rand_ch();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 16'h1400)) - 16'h0200;
  endfunction

  function automatic frag_t rand_frag(input int addr);
    frag_t f;
    f.mode = 2'($urandom_range(0, 3));
    for (int c = 0; c < 3; c++) begin
      f.src[c] = rand_ch();
      f.dst[c] = rand_ch();
    end
    f.a    = rand_ch();
    f.x2   = 2'($urandom_range(0, 3));
    f.y2   = 2'($urandom_range(0, 3));
    f.addr = ADDR_W'(addr);
    return f;
  endfunction

  // driver
  task automatic drive(input frag_t f, input logic v);
    cur      = f;
    in_valid = v;
    in_mode  = f.mode;
    in_src_r = f.src[0]; in_src_g = f.src[1]; in_src_b = f.src[2]; in_src_a = f.a;
    in_dst_r = f.dst[0]; in_dst_g = f.dst[1]; in_dst_b = f.dst[2];
    in_x2    = f.x2;
    in_y2    = f.y2;
    in_addr  = f.addr;
  endtask

  // one clock: evaluate handshakes just after the negedge, then wait for the next negedge
  task automatic cycle();
    logic [ADDR_W+15:0] e;
    #1;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (chk_stall) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_rgb", out_rgb565, held_rgb);
        check("stall_addr", out_addr, held_addr);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_addr, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          last_lat = cyc - acc_q.pop_front();
          last_rgb = out_rgb565;
          check("out_addr", out_addr, e[ADDR_W+15:16]);
          check("out_rgb", out_rgb565, e[15:0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({cur.addr, ref_pixel(cur)});
        acc_q.push_back(cyc);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input frag_t f, input logic [15:0] exp_rgb,
                         input logic chk_lat);
    int n0;
    frag_t idle;
    idle = '0;
    n0 = n_out;
    out_ready = 1'b1;
    drive(f, 1'b1);
    cycle();
    drive(idle, 1'b0);
    for (int k = 0; k < 10 && n_out == n0; k++) cycle();
    if (n_out == n0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check(tag, last_rgb, exp_rgb);
      if (chk_lat) check({tag, "_latency"}, last_lat, 3);
    end
  endtask

  initial begin
    frag_t f, idle;
    int n0, addr;
    idle = '0;
    drive(idle, 1'b0);
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rgb", out_rgb565, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // directed blends
    f = '0; f.mode = 2'd3; f.src[0] = 16'h1000; f.a = 16'h0800; f.addr = 24'h10;
    run_one("alpha_half", f, 16'h8000, 1'b1);
    f = '0; f.mode = 2'd1; f.src[0] = 16'h0C00; f.a = 16'h1000; f.dst[0] = 16'h0C00; f.addr = 24'h11;
    run_one("add_sat", f, 16'hF800, 1'b1);
    f.mode = 2'd2; f.dst[1] = 16'h1000; f.addr = 24'h12;
    run_one("sub_clamp", f, 16'h0000, 1'b0);
    f = '0; f.mode = 2'd0; f.src = {16'h1000, 16'h1000, 16'h1000}; f.addr = 24'h13;
    run_one("disabled", f, 16'hFFFF, 1'b0);
    f = '0; f.mode = 2'd0; f.src[0] = 16'h0040; f.x2 = 2'd3; f.addr = 24'h14;
`ifdef FB_ALPHA_BLEND_DITHER_EN
    run_one("dither_t10", f, 16'h0800, 1'b0);
`else
    run_one("dither_off", f, 16'h0000, 1'b0);
`endif
    f.x2 = 2'd0; f.addr = 24'h15;
    run_one("dither_t0", f, 16'h0000, 1'b0);

    // backpressure: four fragments, out_ready dropped for 5 cycles after the first output
    n0 = n_out;
    for (int k = 0; k < 16; k++) begin
      if (k < 4) drive(rand_frag(k + 1), 1'b1);
      else       drive(idle, 1'b0);
      out_ready = !(k >= 4 && k < 9);
      if (k == 4) begin
        held_rgb  = out_rgb565;
        held_addr = out_addr;
      end
      chk_stall = (k >= 4 && k < 9);
      cycle();
    end
    chk_stall = 1'b0;
    check("bp_count", n_out - n0, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    // reset with three fragments in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(rand_frag(32 + k), 1'b1);
      cycle();
    end
    drive(idle, 1'b0);
    out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    n0 = n_out;
    repeat (8) cycle();
    check("midrst_no_emit", n_out - n0, 0);

    // random traffic, mixed modes and backpressure
    addr = 100;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        drive(rand_frag(addr), 1'b1);
        addr++;
      end else begin
        drive(idle, 1'b0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (in_valid && !in_ready) addr--; // not accepted: reuse address next time
    end

    // drain
    drive(idle, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
